adc_sample_ctrl: RTL and testbench
==================================

// Module: adc_sample_ctrl
// PURPOSE
//  Downstream sequencer/consumer for the 8-bit SAR converter. A programmable tick timer
//  issues single-cycle start pulses and captures the result on the converter's done pulse.
//  It accumulates 2**AVG_LOG2 samples and emits their truncated mean on a valid/ready port.
//  Sits between the SAR core and the system bus/readout logic.
// PARAMETERS
//  DATA_W    8    converter result width
//  DIV_W     16   tick period counter width
//  AVG_LOG2  2    log2 of samples averaged per output (0 = no averaging; 0..4)
//  TIMEOUT   15   max cycles in WAIT for adc_rdy_i before abort
// PORTS
//  clk_i          in   1       clock
//  rst_ni         in   1       reset, asynchronous, active-low
//  en_i           in   1       sampling enable
//  period_i       in   DIV_W   tick period in cycles; 0 treated as 1
//  adc_start_o    out  1       start pulse to converter, one cycle wide
//  adc_rdy_i      in   1       converter done pulse; adc_data_i valid in that cycle
//  adc_data_i     in   DATA_W  converter result
//  out_valid_o    out  1       averaged sample available
//  out_ready_i    in   1       consumer accepts when valid&ready
//  out_data_o     out  DATA_W  averaged sample, held stable while valid&!ready
//  overrun_o      out  1       sticky: output overwritten before being taken
//  late_o         out  1       sticky: tick arrived while conversion busy
//  timeout_o      out  1       sticky: adc_rdy_i not seen within TIMEOUT cycles
//  clr_flags_i    in   1       clears all three sticky flags (same-cycle set wins)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, tick counter 0, accumulator 0, sample count 0.
//  Tick gen: runs only while en_i; counter reloads max(period_i,1)-1 on zero and pulses
//   tick; en_i low clears counter, so first tick comes the cycle after en_i rises.
//  FSM: IDLE -tick&en_i-> START (adc_start_o=1, one cycle) -> WAIT.
//   WAIT: adc_rdy_i -> ACC; wait counter reaching TIMEOUT -> set timeout_o, discard the
//   partial accumulation, -> IDLE.
//   ACC (one cycle): acc += adc_data_i captured in WAIT; cnt++; if cnt==2**AVG_LOG2-1,
//   load out reg with (acc+data)>>AVG_LOG2, clear acc/cnt; -> IDLE.
//  ACC state guarantees >=1 idle cycle between converter done and next start.
//  Tick in any state but IDLE is dropped and sets late_o; no queuing.
//  Accumulator width DATA_W+AVG_LOG2, never overflows; mean truncates (no rounding).
//  Output reg: valid set on load, cleared on valid&ready. Load while valid&!ready:
//   overwrite with new data, set overrun_o. Load in same cycle as valid&ready: no overrun,
//   valid stays 1 with new data.
//  en_i falling: an in-flight conversion completes (WAIT until rdy/timeout) but its sample
//   and partial acc are discarded; acc/cnt cleared; output reg untouched.
//  adc_rdy_i outside WAIT is ignored.
//  Reset mid-conversion: immediate return to reset values; no start pulse issued.
// STRUCTURE
//  Package adc_pkg: FSM state enum (IDLE, START, WAIT, ACC), ADC_DATA_W=8 shared with the
//   SAR core.
//  Sub-module adc_tick_gen: period counter + tick pulse (en, period, tick).
//  Top: FSM, wait counter, accumulator, output register, sticky flags.
// TESTING
//  AVG_LOG2=0, period=20, model rdy 9 cycles after start, data 0xA5 -> out 0xA5 every 20 cyc.
//  AVG_LOG2=2, data 10,11,12,14 -> out_data=11 (47>>2); next group 255x4 -> out 255.
//  out_ready_i held 0 across two averaged outputs -> 2nd overwrites 1st, overrun_o=1;
//   clr_flags_i pulse -> overrun_o=0.
//  period=4 with 9-cycle converter -> late_o=1; starts spaced by conversion+ACC only.
//  Suppress adc_rdy_i -> timeout_o after 15 WAIT cycles, FSM IDLE, next tick starts anew.
//  en_i low in WAIT then rdy -> no output load, acc=0; rst_ni low mid-WAIT -> all outs 0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types for the SAR converter sequencing logic.
package adc_pkg;

  localparam int ADC_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACC   = 2'd3
  } adc_state_e;

  // Sticky flag update: a set in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic flag_q, input logic set_i, input logic clr_i);
    return set_i | (flag_q & ~clr_i);
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Programmable period counter; emits a one-cycle registered tick every max(period,1)
// cycles while enabled, the first one the cycle after enable rises.
module adc_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      tick_d = 1'b1;
      cnt_d  = (period_i == '0) ? '0 : period_i - DIV_W'(1);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/adc_sample_ctrl.sv
// SAR converter sequencer: starts conversions on timer ticks, averages 2**AVG_LOG2
// results and presents the truncated mean on a valid/ready port with sticky error flags.
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int DIV_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  period_i,
  output logic              adc_start_o,
  input  logic              adc_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              overrun_o,
  output logic              late_o,
  output logic              timeout_o,
  input  logic              clr_flags_i
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  adc_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overrun_q, late_q, timeout_q;
  logic              tick_s, start_s, acc_take_s, load_s;
  logic              overrun_set_s, late_set_s, timeout_set_s;

  adc_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .period_i (period_i),
    .tick_o   (tick_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_s && en_i) state_d = START; else state_d = IDLE;
      START:   state_d = WAIT;
      WAIT: begin
        if (adc_rdy_i)               state_d = ACC;
        else if (wait_q == WAIT_LAST) state_d = IDLE;
        else                          state_d = WAIT;
      end
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_s = 1'b0;
    case (state_q)
      START:   start_s = 1'b1;
      default: start_s = 1'b0;
    endcase
  end

  // A conversion whose window saw en_i low is tainted; its sample is dropped in ACC.
  always_comb begin
    wait_d        = (state_q == WAIT) ? wait_q + WAIT_W'(1) : '0;
    sample_d      = (state_q == WAIT && adc_rdy_i) ? adc_data_i : sample_q;
    discard_d     = (state_q == IDLE) ? 1'b0 : (discard_q | ~en_i);
    timeout_set_s = (state_q == WAIT) && !adc_rdy_i && (wait_q == WAIT_LAST);
    late_set_s    = tick_s && (state_q != IDLE);
    acc_sum_s     = acc_q + ACC_W'(sample_q);
    acc_take_s    = (state_q == ACC) && en_i && !discard_q;
    load_s        = acc_take_s && (cnt_q == CNT_LAST);
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    if (!en_i || timeout_set_s || load_s) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_take_s) begin
      acc_d = acc_sum_s;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Output register: a fresh load always wins over the handshake clearing valid.
  always_comb begin
    valid_d       = valid_q;
    data_d        = data_q;
    overrun_set_s = 1'b0;
    if (load_s) begin
      valid_d       = 1'b1;
      data_d        = DATA_W'(acc_sum_s >> AVG_LOG2);
      overrun_set_s = valid_q && !out_ready_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q    <= '0;
      sample_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      late_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      sample_q  <= sample_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= sticky_next(overrun_q, overrun_set_s, clr_flags_i);
      late_q    <= sticky_next(late_q, late_set_s, clr_flags_i);
      timeout_q <= sticky_next(timeout_q, timeout_set_s, clr_flags_i);
    end
  end

  assign adc_start_o = start_s;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign overrun_o   = overrun_q;
  assign late_o      = late_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Randomized bench for adc_sample_ctrl against a conversion-window/sample-group model.
module tb_adc_sample_ctrl;

  localparam int DW = 8;
  localparam int PW = 16;
  localparam int L  = 2;
  localparam int TO = 15;
  localparam int N  = 1 << L;

  logic          clk = 1'b0;
  logic          rst_n, en, adc_rdy, out_ready, clr;
  logic [PW-1:0] period;
  logic [DW-1:0] adc_data;
  logic          adc_start, out_valid, overrun, late, timeout;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  adc_sample_ctrl #(.DATA_W(DW), .DIV_W(PW), .AVG_LOG2(L), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .period_i    (period),
    .adc_start_o (adc_start),
    .adc_rdy_i   (adc_rdy),
    .adc_data_i  (adc_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .overrun_o   (overrun),
    .late_o      (late),
    .timeout_o   (timeout),
    .clr_flags_i (clr)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: conversion windows in absolute cycle numbers
  int  s_c = -1000, busy_end = -1000, wait_last = -1000, rdy_at = -1000, acc_at = -1000;
  int  acc_val = 0;
  bit  to_plan = 1'b0, conv_ok = 1'b0, en_prev = 1'b0;
  int  run_r = 0, run_per = 1;
  int  grp_sum = 0, grp_n = 0;
  bit  m_valid = 1'b0, m_over = 1'b0, m_late = 1'b0, m_to = 1'b0;
  int  m_data = 0;
  logic [DW-1:0] dq[$];

  int ph_per = 1, ph_dly = 0, ph_to_pct = 0, ph_rdy_pct = 100;
  int ph_flip_pct = 0, ph_clr_pct = 0, ph_spur_pct = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_outputs();
    chk_eq("adc_start", 32'(adc_start), 32'(cyc == s_c));
    chk_eq("out_valid", 32'(out_valid), 32'(m_valid));
    chk_eq("out_data",  32'(out_data),  32'(m_data));
    chk_eq("overrun",   32'(overrun),   32'(m_over));
    chk_eq("late",      32'(late),      32'(m_late));
    chk_eq("timeout",   32'(timeout),   32'(m_to));
  endtask

  // en_mode: 0 force low, 1 force high, 2 random toggling
  task automatic step(input int en_mode);
    bit busy_c, tick, load, over_set, late_set, to_set;
    int load_val, d;
    @(negedge clk);
    chk_outputs();
    if (en_mode == 0)      en = 1'b0;
    else if (en_mode == 1) en = 1'b1;
    else if ($urandom_range(99) < ph_flip_pct) en = ~en;
    period    = PW'(ph_per);
    out_ready = ($urandom_range(99) < ph_rdy_pct);
    clr       = ($urandom_range(99) < ph_clr_pct);
    adc_rdy   = 1'b0;
    adc_data  = DW'($urandom);
    if (cyc == rdy_at) begin
      adc_rdy = 1'b1;
      if (dq.size() > 0) adc_data = dq.pop_front();
    end else if (!(cyc >= s_c + 1 && cyc <= wait_last) && $urandom_range(99) < ph_spur_pct) begin
      adc_rdy = 1'b1;
    end

    busy_c   = (cyc >= s_c) && (cyc <= busy_end);
    tick     = en_prev && (((cyc - 1 - run_r) % run_per) == 0);
    load     = 1'b0;
    load_val = 0;
    over_set = 1'b0;
    late_set = 1'b0;
    to_set   = 1'b0;
    if (busy_c && !en) conv_ok = 1'b0;
    if (cyc == acc_at && conv_ok && en) begin
      grp_sum += acc_val;
      grp_n++;
      if (grp_n == N) begin
        load     = 1'b1;
        load_val = grp_sum >> L;
        grp_sum  = 0;
        grp_n    = 0;
      end
    end
    if (!en) begin
      grp_sum = 0;
      grp_n   = 0;
    end
    if (to_plan && cyc == s_c + TO) begin
      to_set  = 1'b1;
      grp_sum = 0;
      grp_n   = 0;
    end
    if (adc_rdy && cyc == rdy_at) begin
      acc_at  = cyc + 1;
      acc_val = int'(adc_data);
    end
    if (tick) begin
      if (!busy_c && en) begin
        s_c     = cyc + 1;
        conv_ok = 1'b1;
        if ($urandom_range(99) < ph_to_pct) begin
          to_plan   = 1'b1;
          rdy_at    = -1000;
          wait_last = s_c + TO;
          busy_end  = s_c + TO;
        end else begin
          to_plan   = 1'b0;
          d         = (ph_dly != 0) ? ph_dly : int'($urandom_range(1, TO));
          rdy_at    = s_c + d;
          wait_last = rdy_at;
          busy_end  = rdy_at + 1;
        end
      end else if (busy_c) begin
        late_set = 1'b1;
      end
    end
    if (load) begin
      over_set = m_valid && !out_ready;
      m_valid  = 1'b1;
      m_data   = load_val;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    m_over = over_set | (m_over & !clr);
    m_late = late_set | (m_late & !clr);
    m_to   = to_set   | (m_to   & !clr);
    if (en && !en_prev) begin
      run_r   = cyc;
      run_per = (ph_per == 0) ? 1 : ph_per;
    end
    en_prev = en;
    cyc++;
  endtask

  task automatic phase(input int ncyc, input int per, input int dly, input int to_pct,
                       input int rdy_pct, input int flip_pct, input int clr_pct, input int spur_pct);
    ph_per      = per;
    ph_dly      = dly;
    ph_to_pct   = to_pct;
    ph_rdy_pct  = rdy_pct;
    ph_flip_pct = flip_pct;
    ph_clr_pct  = clr_pct;
    ph_spur_pct = spur_pct;
    step(0);
    step(0);
    step(1);
    for (int i = 0; i < ncyc; i++) step((flip_pct != 0) ? 2 : 1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; en = 1'b0; adc_rdy = 1'b0; out_ready = 1'b0; clr = 1'b0;
    period = '0; adc_data = '0;
    repeat (3) @(negedge clk);
    chk_outputs();
    rst_n = 1'b1;

    // mean of 10,11,12,14 is 11; four 255s give 255
    dq = '{8'd10, 8'd11, 8'd12, 8'd14, 8'd255, 8'd255, 8'd255, 8'd255};
    phase(180, 20, 9, 0, 100, 0, 0, 0);
    // consumer stalled across two averages, then drained with flag clears
    phase(110, 12, 5, 0, 0, 0, 0, 0);
    phase(40, 12, 5, 0, 100, 0, 20, 0);
    // period shorter than conversion
    phase(100, 4, 9, 0, 100, 0, 0, 20);
    // suppressed converter
    phase(80, 30, 0, 100, 100, 0, 0, 0);
    phase(30, 30, 0, 0, 100, 0, 20, 0);
    for (int k = 0; k < 8; k++)
      phase(400, int'($urandom_range(0, 25)), 0, 10, 70, 3, 1, 10);

    // reset asserted in the middle of a WAIT
    phase(0, 40, 0, 100, 100, 0, 0, 0);
    base = cyc;
    for (int k = 0; k < 60 && !(s_c >= base && cyc == s_c + 4); k++) step(1);
    chk_eq("wait_reached", 32'(cyc == s_c + 4), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_start",   32'(adc_start), 32'd0);
    chk_eq("rst_valid",   32'(out_valid), 32'd0);
    chk_eq("rst_data",    32'(out_data),  32'd0);
    chk_eq("rst_overrun", 32'(overrun),   32'd0);
    chk_eq("rst_late",    32'(late),      32'd0);
    chk_eq("rst_timeout", 32'(timeout),   32'd0);
    en = 1'b0;
    @(negedge clk);
    chk_eq("rst_hold_start", 32'(adc_start), 32'd0);
    chk_eq("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
